dft_frame_sequencer: RTL
========================

Name: dft_frame_sequencer

Overview:
- Parametrised frame buffer and sequencer that sits between a register/bus front end and a streaming DFT core with the dft_top interface: a next pulse, then WORDS cycles of LANES-wide input, then a next_out pulse and WORDS cycles of output.
- Holds one input frame and one captured output frame.
- Generates the core handshake, overlaps feed and capture for short-latency cores, and reports done, busy-violation and timeout status.
- Replaces hand-sequenced per-word register pokes for any DFT/FFT size or lane count.

Parameters:
- DATA_W, 16, bits per lane sample.
- LANES, 4, samples per word; lane 0 occupies the LSBs.
- WORDS, 32, words per frame; must be a power of two, ≥2.
- TIMEOUT, 4096, max cycles from core_next_o to core_next_out_i.
- IDX_W, $clog2(WORDS), derived; do not override.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- wr_en_i  in  1  input-frame write strobe.
- wr_idx_i  in  IDX_W  input word index.
- wr_data_i  in  LANES*DATA_W  input word.
- start_i  in  1  frame start request.
- rd_idx_i  in  IDX_W  output word index.
- rd_data_o  out  LANES*DATA_W  output word, registered, 1-cycle latency.
- busy_o  out  1  frame in progress.
- done_o  out  1  sticky frame-complete flag.
- err_busy_o  out  1  sticky: start or write attempted while busy.
- err_timeout_o  out  1  sticky: core never answered.
- core_next_o  out  1  one-cycle start pulse to the core.
- core_x_o  out  LANES*DATA_W  input word to the core.
- core_next_out_i  in  1  core output-valid pulse.
- core_y_i  in  LANES*DATA_W  core output word.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, both counters 0. Memory contents are not reset.
- FSM states:
  - IDLE: start_i accepted → KICK; done_o, err_busy_o and err_timeout_o cleared in the same edge.
  - KICK: core_next_o=1 for exactly one cycle → RUN.
  - RUN: feed and capture sub-counters run independently; when both finish → IDLE.
- busy_o=1 in KICK and RUN, 0 in IDLE.
- Start timing: start_i high at cycle T in IDLE gives core_next_o at T+1 and core_x_o = in_mem[k] at T+2+k, for k=0..WORDS-1.
- core_x_o is 0 outside the feed window.
- Capture arming and timing:
  - Capture arms at KICK. The first core_next_out_i seen at or after T+1 (including during feed) at cycle C writes core_y_i into out_mem[k] at C+1+k, for k=0..WORDS-1.
  - core_next_out_i is ignored in IDLE, before arming, and while capturing.
- Done timing: done_o rises at C+WORDS+1, the same edge busy_o falls. It stays high until an accepted start or reset.
- Timeout:
  - The timeout counter runs from T+1 until core_next_out_i is seen.
  - If TIMEOUT cycles elapse with no core_next_out_i: set err_timeout_o, abort feed, go to IDLE, leave done_o=0. Partial out_mem contents are retained.
- Busy violations: start_i or wr_en_i while busy_o=1 are ignored and set err_busy_o. The current frame is unaffected.
- Writes in IDLE: in_mem[wr_idx_i] updates at the clock edge.
  - A write and a start in the same IDLE cycle both take effect, and the written word is fed.
- Reads:
  - Allowed at any time; rd_data_o = out_mem[rd_idx_i] sampled at the previous edge.
  - During capture a read may return the old or the new word.
- Start in the cycle done_o is high: accepted normally, and done_o clears on that edge.
- Reset mid-frame: next edge returns everything to reset values and core_next_o/core_x_o become 0. The core must be reset alongside.
- Index wrap: counters are IDX_W wide plus a terminal flag. No wrap beyond WORDS words.

Test Plan:
- Real dft_top core, WORDS=32, LANES=4:
  - Write word j = lanes {4j,4j+1,4j+2,4j+3} for j=0..31, then start → done_o=1.
  - rd_idx 0 returns lanes {0fc0,1000,faa3,04cf}; rd_idx 31 returns {0248,fd3b,04d3,fab4}.
  - Rerun with a 128 offset on every input sample → word 0 = {2fc0,3000,faa3,04cf}.
- Behavioural core, latency 40, y=x+1, start at T:
  - core_next_o at T+1 only; core_x_o word 0 at T+2; done_o at T+74.
  - out_mem[j] = in_mem[j]+1 in each lane.
- Behavioural core, latency 5 (capture overlaps feed) → all 32 words captured correctly, done_o at T+39.
- start_i and wr_en_i pulsed at T+10 during a frame → err_busy_o=1, in_mem unchanged, single done_o, outputs correct.
- Core never responds, TIMEOUT=64 → err_timeout_o=1 at T+65, busy_o=0, done_o=0. The next start clears err_timeout_o.
- Reset asserted at T+12 mid-feed:
  - Next cycle: busy_o=0 and core_x_o=0.
  - A subsequent reload and start completes with correct results.
  - A start issued the same cycle done_o rises is accepted and clears done_o.

Source files
------------

// File: rtl/dft_frame_sequencer.sv
// Frame buffer and handshake sequencer for a streaming DFT core: feeds one
// input frame after a start pulse and captures one output frame on next_out.
module dft_frame_sequencer #(
  parameter int DATA_W  = 16,
  parameter int LANES   = 4,
  parameter int WORDS   = 32,
  parameter int TIMEOUT = 4096,
  parameter int IDX_W   = $clog2(WORDS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en_i,
  input  logic [IDX_W-1:0]          wr_idx_i,
  input  logic [LANES*DATA_W-1:0]   wr_data_i,
  input  logic                      start_i,
  input  logic [IDX_W-1:0]          rd_idx_i,
  output logic [LANES*DATA_W-1:0]   rd_data_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_busy_o,
  output logic                      err_timeout_o,
  output logic                      core_next_o,
  output logic [LANES*DATA_W-1:0]   core_x_o,
  input  logic                      core_next_out_i,
  input  logic [LANES*DATA_W-1:0]   core_y_i
);

  localparam int WORD_W = LANES * DATA_W;
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_KICK = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  logic [WORD_W-1:0] in_mem  [WORDS];
  logic [WORD_W-1:0] out_mem [WORDS];

  logic [1:0]       state;
  logic [IDX_W-1:0] feed_idx;
  logic [IDX_W-1:0] cap_idx;
  logic             feed_done;
  logic             cap_wait;
  logic             cap_active;
  logic             cap_done;
  logic [TO_W-1:0]  to_cnt;

  logic idle;
  logic cap_armed;
  logic feed_fin;
  logic cap_fin;

  assign idle        = (state == S_IDLE);
  assign busy_o      = !idle;
  assign core_next_o = (state == S_KICK);
  // The KICK cycle itself is already a valid response window.
  assign cap_armed   = (state == S_KICK) || cap_wait;
  assign feed_fin    = feed_done || ((state == S_RUN) && (feed_idx == LAST_IDX));
  assign cap_fin     = cap_done || (cap_active && (cap_idx == LAST_IDX));

  // NOTE: frame memories carry no reset; only control state does, so they map onto plain RAM.
  always_ff @(posedge clk) begin
    if (!reset && idle && wr_en_i) in_mem[wr_idx_i] <= wr_data_i;
    if (!reset && cap_active)      out_mem[cap_idx] <= core_y_i;
  end

  // NOTE: every register here uses <= so later statements in this block see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      feed_idx      <= '0;
      cap_idx       <= '0;
      feed_done     <= 1'b0;
      cap_wait      <= 1'b0;
      cap_active    <= 1'b0;
      cap_done      <= 1'b0;
      to_cnt        <= '0;
      core_x_o      <= '0;
      rd_data_o     <= '0;
      done_o        <= 1'b0;
      err_busy_o    <= 1'b0;
      err_timeout_o <= 1'b0;
    end else begin
      rd_data_o <= out_mem[rd_idx_i];
      if (busy_o && (start_i || wr_en_i)) err_busy_o <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start_i) begin
            state         <= S_KICK;
            done_o        <= 1'b0;
            err_busy_o    <= 1'b0;
            err_timeout_o <= 1'b0;
            feed_idx      <= '0;
            cap_idx       <= '0;
            feed_done     <= 1'b0;
            cap_wait      <= 1'b0;
            cap_active    <= 1'b0;
            cap_done      <= 1'b0;
            to_cnt        <= '0;
          end
        end
        S_KICK: begin
          state    <= S_RUN;
          core_x_o <= in_mem[0];
        end
        S_RUN: begin
          if (!feed_done) begin
            if (feed_idx == LAST_IDX) begin
              core_x_o  <= '0;
              feed_done <= 1'b1;
            end else begin
              feed_idx <= feed_idx + 1'b1;
              core_x_o <= in_mem[feed_idx + 1'b1];
            end
          end
          if (cap_active) begin
            if (cap_idx == LAST_IDX) begin
              cap_active <= 1'b0;
              cap_done   <= 1'b1;
            end else begin
              cap_idx <= cap_idx + 1'b1;
            end
          end
          if (feed_fin && cap_fin) begin
            state  <= S_IDLE;
            done_o <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Response detection and timeout override the feed path when they fire.
      if (cap_armed) begin
        if (core_next_out_i) begin
          cap_wait   <= 1'b0;
          cap_active <= 1'b1;
          cap_idx    <= '0;
        end else if (to_cnt == TO_LAST) begin
          cap_wait      <= 1'b0;
          err_timeout_o <= 1'b1;
          feed_done     <= 1'b1;
          core_x_o      <= '0;
          state         <= S_IDLE;
        end else begin
          cap_wait <= 1'b1;
          to_cnt   <= to_cnt + 1'b1;
        end
      end
    end
  end

endmodule
